// File: rtl/dpb_pkg.sv
// Shared definitions for the data_processing_block (DPB) and its schedulers.
//   - DPB mode encodings
//   - arbiter state encoding
//   - default sizing for dpb_rr_arbiter
//   - index-width helper used by the arbiter and the picker
package dpb_pkg;

    localparam int unsigned DEF_NUM_REQ   = 4;
    localparam int unsigned DEF_DATA_W    = 8;
    localparam int unsigned DEF_MAX_BURST = 4;

    // Beat counter width; bounds MAX_BURST to 15
    localparam int unsigned BEAT_CNT_W = 4;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'b00,
        MODE_INC    = 2'b01,
        MODE_INV    = 2'b10,
        MODE_GAIN   = 2'b11
    } dpb_mode_e;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    // Width of a requester index; at least one bit so single-bit vectors stay legal
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dpb_rr_pick.sv
// Combinational rotating-priority picker.
// Starting at rr_ptr and moving upward with wrap-around, returns the first set
// bit of req.
// Ports:
//   req    in  NUM_REQ  request vector
//   rr_ptr in  IDX_W    index with highest priority this cycle
//   any    out 1        at least one request is set
//   idx    out IDX_W    winning index (0 when any is low)
module dpb_rr_pick
    import dpb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    localparam int unsigned IDX_W  = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               any,
    output logic [IDX_W-1:0]   idx
);

    // One extra bit so rr_ptr + offset never overflows before the modulo
    localparam int unsigned SUM_W = IDX_W + 1;

    logic [SUM_W-1:0] cand_sum;
    logic [IDX_W-1:0] cand;

    // Scan NUM_REQ positions from rr_ptr; the first hit wins
    always_comb begin
        any      = 1'b0;
        idx      = '0;
        cand_sum = '0;
        cand     = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand_sum = {1'b0, rr_ptr} + SUM_W'(k);
            if (cand_sum >= SUM_W'(NUM_REQ)) begin
                cand_sum = cand_sum - SUM_W'(NUM_REQ);
            end
            cand = cand_sum[IDX_W-1:0];
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/dpb_rr_arbiter.sv
// Round-robin arbiter that shares one DPB between NUM_REQ requesters.
// A requester is granted for up to MAX_BURST beats; each accepted beat is
// tagged with its source so the DPB result is routed back to that requester.
// The DPB is instantiated by the parent and shares this block's reset.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   req_valid/req_ready/req_data/req_mode   per-requester input channel
//   dp_valid/dp_ready/dp_data/dp_mode       to/from DPB input side
//   dp_out_valid/dp_out_ready/dp_out_data   from/to DPB output side
//   rsp_valid/rsp_ready                     per-requester result handshake
//   rsp_data                                result data, broadcast
module dpb_rr_arbiter
    import dpb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ*2-1:0]      req_mode,
    output logic                      dp_valid,
    input  logic                      dp_ready,
    output logic [DATA_W-1:0]         dp_data,
    output logic [1:0]                dp_mode,
    input  logic                      dp_out_valid,
    output logic                      dp_out_ready,
    input  logic [DATA_W-1:0]         dp_out_data,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [DATA_W-1:0]         rsp_data
);

    localparam int unsigned IDX_W = idx_w(NUM_REQ);
    localparam int unsigned CNT_W = BEAT_CNT_W;

    arb_state_e       state_q,     state_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0] rr_ptr_q,    rr_ptr_d;
    logic [IDX_W-1:0] tag_q,       tag_d;
    logic [CNT_W-1:0] beat_cnt_q,  beat_cnt_d;

    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;
    logic             granted;
    logic             owner_valid;
    logic             accept;
    logic             last_beat;
    logic [IDX_W-1:0] next_ptr;

    dpb_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req    (req_valid),
        .rr_ptr (rr_ptr_q),
        .any    (pick_any),
        .idx    (pick_idx)
    );

    // Steer the granted requester onto the DPB input; everything is gated by state
    always_comb begin
        granted     = (state_q == ARB_GRANT);
        owner_valid = req_valid[grant_idx_q];
        dp_valid    = granted && owner_valid;
        dp_data     = '0;
        dp_mode     = '0;
        req_ready   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (granted && (grant_idx_q == IDX_W'(i))) begin
                dp_data      = req_data[i*DATA_W +: DATA_W];
                dp_mode      = req_mode[i*2 +: 2];
                req_ready[i] = dp_ready;
            end
        end
        accept = dp_valid && dp_ready;
    end

    // Route the DPB result to the requester recorded in tag
    always_comb begin
        rsp_valid    = '0;
        dp_out_ready = rsp_ready[tag_q];
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (tag_q == IDX_W'(i)) begin
                rsp_valid[i] = dp_out_valid;
            end
        end
    end

    assign rsp_data = dp_out_data;

    // Next-state: grant, burst counting, release and pointer rotation
    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        rr_ptr_d    = rr_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        tag_d       = tag_q;
        next_ptr    = (grant_idx_q == IDX_W'(NUM_REQ - 1)) ? '0
                                                           : IDX_W'(grant_idx_q + IDX_W'(1));
        last_beat   = (CNT_W'(beat_cnt_q + CNT_W'(1)) == CNT_W'(MAX_BURST));

        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_d     = ARB_GRANT;
                    grant_idx_d = pick_idx;
                    beat_cnt_d  = '0;
                end
            end
            ARB_GRANT: begin
                // tag moves on the same edge the DPB captures this beat
                if (accept) begin
                    beat_cnt_d = CNT_W'(beat_cnt_q + CNT_W'(1));
                    tag_d      = grant_idx_q;
                end
                // Release on a full burst or as soon as the owner goes quiet
                if (!owner_valid || (accept && last_beat)) begin
                    state_d  = ARB_IDLE;
                    rr_ptr_d = next_ptr;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State and bookkeeping registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            grant_idx_q <= '0;
            rr_ptr_q    <= '0;
            beat_cnt_q  <= '0;
            tag_q       <= '0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            tag_q       <= tag_d;
        end
    end

endmodule

// File: tb/tb_dpb_rr_arbiter.sv
// Bench for dpb_rr_arbiter: a simple DPB register stage sits behind the
// arbiter, and a cycle-level reference model predicts grants and results.
module tb_dpb_rr_arbiter;
    import dpb_pkg::*;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NR-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NR*DW-1:0] req_data;
    logic [NR*2-1:0]  req_mode;
    logic             dp_valid, dp_ready, dp_out_valid, dp_out_ready;
    logic [DW-1:0]    dp_data, dp_out_data, rsp_data;
    logic [1:0]       dp_mode;

    logic          tv [NR];
    logic [DW-1:0] td [NR];
    logic [1:0]    tm [NR];

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            req_valid[i]         = tv[i];
            req_data[i*DW +: DW] = td[i];
            req_mode[i*2 +: 2]   = tm[i];
        end
    end

    dpb_rr_arbiter #(
        .NUM_REQ   (NR),
        .DATA_W    (DW),
        .MAX_BURST (MB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_data     (req_data),
        .req_mode     (req_mode),
        .dp_valid     (dp_valid),
        .dp_ready     (dp_ready),
        .dp_data      (dp_data),
        .dp_mode      (dp_mode),
        .dp_out_valid (dp_out_valid),
        .dp_out_ready (dp_out_ready),
        .dp_out_data  (dp_out_data),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data)
    );

    function automatic logic [DW-1:0] dpb_fn(input logic [DW-1:0] d, input logic [1:0] m);
        case (m)
            2'b00:   return d;
            2'b01:   return DW'(d + 8'd1);
            2'b10:   return ~d;
            default: return {d[DW-2:0], 1'b0};
        endcase
    endfunction

    // Behavioural DPB: single output register, ready when empty or draining
    logic          dpb_vld;
    logic [DW-1:0] dpb_dat;
    assign dp_ready     = !dpb_vld || dp_out_ready;
    assign dp_out_valid = dpb_vld;
    assign dp_out_data  = dpb_dat;

    always @(posedge clk) begin
        if (!rst_n) begin
            dpb_vld <= 1'b0;
            dpb_dat <= '0;
        end else if (dp_valid && dp_ready) begin
            dpb_vld <= 1'b1;
            dpb_dat <= dpb_fn(dp_data, dp_mode);
        end else if (dp_out_ready) begin
            dpb_vld <= 1'b0;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: who owns the DPB, whose turn is next, and what results are due
    typedef struct {
        int            src;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    bit   m_grant;
    int   m_owner, m_ptr, m_beats, m_tag;
    bit   acc_last;
    int   acc_src_last;
    int   obs_acc_cnt;

    function automatic void model_reset();
        m_grant = 0;
        m_owner = 0;
        m_ptr   = 0;
        m_beats = 0;
        m_tag   = 0;
        exp_q.delete();
    endfunction

    // One clock: compare at the falling edge, advance the model at the rising edge
    task automatic step();
        logic [NR-1:0] e_rr, e_rv;
        bit            m_rdy, e_dv, acc, found;
        int            pick;
        @(negedge clk);
        m_rdy = (exp_q.size() == 0) || rsp_ready[m_tag];
        e_rr  = '0;
        if (m_grant && m_rdy) e_rr[m_owner] = 1'b1;
        e_dv  = m_grant && tv[m_owner];
        e_rv  = '0;
        if (exp_q.size() > 0) e_rv[exp_q[0].src] = 1'b1;
        check_eq("req_ready", 32'(req_ready), 32'(e_rr));
        check_eq("dp_valid", 32'(dp_valid), 32'(e_dv));
        check_eq("rsp_valid", 32'(rsp_valid), 32'(e_rv));
        check_eq("dp_out_ready", 32'(dp_out_ready), 32'(rsp_ready[m_tag]));
        if (m_grant) begin
            check_eq("dp_data", 32'(dp_data), 32'(td[m_owner]));
            check_eq("dp_mode", 32'(dp_mode), 32'(tm[m_owner]));
        end else begin
            check_eq("dp_data_idle", 32'(dp_data), 32'h0);
            check_eq("dp_mode_idle", 32'(dp_mode), 32'h0);
        end
        if (exp_q.size() > 0) check_eq("rsp_data", 32'(rsp_data), 32'(exp_q[0].data));
        if (|(req_ready & req_valid)) obs_acc_cnt++;
        acc          = e_dv && m_rdy && rst_n;
        acc_src_last = m_owner;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
            acc = 0;
        end else begin
            if (exp_q.size() > 0 && rsp_ready[m_tag]) void'(exp_q.pop_front());
            if (!m_grant) begin
                found = 0;
                pick  = 0;
                for (int j = 0; j < NR; j++) begin
                    if (!found && tv[(m_ptr + j) % NR]) begin
                        found = 1;
                        pick  = (m_ptr + j) % NR;
                    end
                end
                if (found) begin
                    m_grant = 1;
                    m_owner = pick;
                    m_beats = 0;
                end
            end else if (!tv[m_owner]) begin
                m_grant = 0;
                m_ptr   = (m_owner + 1) % NR;
            end else if (acc) begin
                exp_q.push_back('{src: m_owner, data: dpb_fn(td[m_owner], tm[m_owner])});
                m_tag = m_owner;
                m_beats++;
                if (m_beats == MB) begin
                    m_grant = 0;
                    m_ptr   = (m_owner + 1) % NR;
                end
            end
        end
        acc_last = acc;
        #1;
    endtask

    // Random requester behaviour: hold each item until accepted, then refill or go quiet
    task automatic auto_drive();
        for (int i = 0; i < NR; i++) begin
            if (acc_last && acc_src_last == i) begin
                if ($urandom % 4 != 0) begin
                    td[i] = DW'($urandom);
                    tm[i] = 2'($urandom);
                end else begin
                    tv[i] = 1'b0;
                end
            end else if (!tv[i] && ($urandom % 3 == 0)) begin
                tv[i] = 1'b1;
                td[i] = DW'($urandom);
                tm[i] = 2'($urandom);
            end
            rsp_ready[i] = ($urandom % 5) != 0;
        end
    endtask

    initial begin
        int n, guard;
        rst_n       = 1'b0;
        rsp_ready   = 4'b1110;
        obs_acc_cnt = 0;
        acc_last    = 0;
        for (int i = 0; i < NR; i++) begin
            tv[i] = 1'b0;
            td[i] = '0;
            tm[i] = '0;
        end
        model_reset();

        // Reset state
        step();
        step();
        check_eq("rst_req_ready", 32'(req_ready), 32'h0);
        check_eq("rst_dp_valid", 32'(dp_valid), 32'h0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check_eq("rst_dp_data", 32'(dp_data), 32'h0);
        check_eq("rst_out_ready", 32'(dp_out_ready), 32'h0);
        rst_n     = 1'b1;
        rsp_ready = '1;
        step();

        // Single requester: one idle cycle, then a beat, result next cycle
        tv[1] = 1'b1;
        td[1] = 8'h10;
        tm[1] = MODE_INC;
        step();
        check_eq("single_dp_valid", 32'(dp_valid), 32'h1);
        check_eq("single_req_ready", 32'(req_ready), 32'h2);
        step();
        tv[1] = 1'b0;
        #1;
        check_eq("single_rsp_valid", 32'(rsp_valid), 32'h2);
        check_eq("single_rsp_data", 32'(rsp_data), 32'h11);
        repeat (3) step();

        // All requesting: bursts of MB beats plus one idle cycle each
        for (int i = 0; i < NR; i++) begin
            tv[i] = 1'b1;
            td[i] = DW'($urandom);
            tm[i] = 2'($urandom);
        end
        td[2] = 8'h0F;
        tm[2] = MODE_INV;
        obs_acc_cnt = 0;
        repeat (20) step();
        check_eq("burst_throughput", 32'(obs_acc_cnt), 32'd16);
        for (int i = 0; i < NR; i++) tv[i] = 1'b0;
        repeat (3) step();

        // Short burst from req 3, then req 0 must beat req 1
        tv[3] = 1'b1;
        td[3] = 8'hA5;
        tm[3] = MODE_BYPASS;
        n     = 0;
        guard = 0;
        while (n < 2 && guard < 20) begin
            step();
            if (acc_last) n++;
            guard++;
        end
        check_eq("short_beats", 32'(n), 32'd2);
        tv[3] = 1'b0;
        tv[0] = 1'b1;
        td[0] = 8'h41;
        tm[0] = MODE_GAIN;
        tv[1] = 1'b1;
        step();
        step();
        check_eq("short_next_grant", 32'(req_ready), 32'h1);

        // Backpressure on requester 0 mid-burst
        tv[1] = 1'b0;
        step();
        rsp_ready[0] = 1'b0;
        #1;
        check_eq("bp_req_ready", 32'(req_ready), 32'h0);
        check_eq("bp_rsp_valid", 32'(rsp_valid), 32'h1);
        check_eq("bp_rsp_data", 32'(rsp_data), 32'h82);
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq("bp_stall", 32'(req_ready), 32'h0);
        end
        rsp_ready[0] = 1'b1;
        repeat (6) step();
        tv[0] = 1'b0;
        repeat (3) step();

        // Reset in the middle of a grant to req 2
        tv[2] = 1'b1;
        td[2] = 8'h5A;
        tm[2] = MODE_BYPASS;
        guard = 0;
        do begin
            step();
            guard++;
        end while (!(acc_last && acc_src_last == 2) && guard < 20);
        check_eq("rst_mid_reached", 32'(guard < 20), 32'h1);
        rst_n = 1'b0;
        step();
        check_eq("rst_mid_req_ready", 32'(req_ready), 32'h0);
        check_eq("rst_mid_rsp_valid", 32'(rsp_valid), 32'h0);
        check_eq("rst_mid_dp_valid", 32'(dp_valid), 32'h0);
        rst_n = 1'b1;
        step();
        check_eq("rst_regrant", 32'(req_ready), 32'h4);

        // Pointer wrap: req 3 then req 0
        tv[2] = 1'b0;
        tv[0] = 1'b1;
        tv[3] = 1'b1;
        step();
        step();
        check_eq("wrap_first", 32'(req_ready), 32'h8);
        step();
        tv[3] = 1'b0;
        step();
        step();
        check_eq("wrap_second", 32'(req_ready), 32'h1);
        tv[0] = 1'b0;
        repeat (3) step();

        // Randomised traffic with occasional resets
        repeat (3000) begin
            step();
            auto_drive();
            rst_n = ($urandom % 600) != 0;
        end
        rst_n     = 1'b1;
        rsp_ready = '1;
        for (int i = 0; i < NR; i++) tv[i] = 1'b0;
        repeat (6) step();
        check_eq("drain_rsp_valid", 32'(rsp_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dpb_rr_arbiter.md
# dpb_rr_arbiter

Round-robin arbiter and scheduler that shares one `data_processing_block` (DPB) instance between `NUM_REQ` independent requesters. Each requester supplies its own data and mode. The arbiter grants the DPB to one requester at a time for bursts of up to `MAX_BURST` beats. It tags each accepted beat and routes the DPB result back to the originating requester's response port. It sits directly in front of and behind the DPB, and is reset together with it.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (2..8)
- `DATA_W`, 8, data width; must match the DPB
- `MAX_BURST`, 4, maximum beats per grant (1..15)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `req_valid`  in  NUM_REQ  per-requester input valid
- `req_ready`  out  NUM_REQ  per-requester input ready
- `req_data`  in  NUM_REQ*DATA_W  packed request data; requester i occupies bits [i*DATA_W +: DATA_W]
- `req_mode`  in  NUM_REQ*2  packed per-requester DPB mode
- `dp_valid`  out  1  to DPB `valid_in`
- `dp_ready`  in  1  from DPB `ready_in`
- `dp_data`  out  DATA_W  to DPB `data_in`
- `dp_mode`  out  2  to DPB `mode`
- `dp_out_valid`  in  1  from DPB `valid_out`
- `dp_out_ready`  out  1  to DPB `ready_out`
- `dp_out_data`  in  DATA_W  from DPB `data_out`
- `rsp_valid`  out  NUM_REQ  per-requester result valid
- `rsp_ready`  in  NUM_REQ  per-requester result ready
- `rsp_data`  out  DATA_W  result data, broadcast to all requesters

## Operation
- Arbiter state machine (FSM), two states:
  - IDLE: no grant is held.
  - GRANT: a grant is held.
- Registers:
  - `grant_idx`
  - `rr_ptr`, the next-highest-priority index
  - `beat_cnt`
  - `tag`, the requester index of the item held in the DPB output register
- IDLE:
  - If any `req_valid` is set, the rotating-priority pick starts at `rr_ptr`.
  - `grant_idx` ← winner, `beat_cnt` ← 0, and the FSM goes to GRANT.
  - If no request is present, the FSM stays in IDLE.
- GRANT datapath, combinational:
  - `dp_valid` = `req_valid[grant_idx]`
  - `dp_data` and `dp_mode` come from the requester at `grant_idx`.
  - `req_ready[i]` = `dp_ready` && state==GRANT && i==`grant_idx`.
  - All other `req_ready` bits are 0.
- Beat accept is `dp_valid && dp_ready`. On each accept:
  - `beat_cnt` increments.
  - `tag` ← `grant_idx`.
- Release from GRANT to IDLE, with `rr_ptr` ← (`grant_idx`+1) mod `NUM_REQ`, on either condition:
  - the accept that makes `beat_cnt` == `MAX_BURST`;
  - any cycle in GRANT where `req_valid[grant_idx]`==0.
- Result routing:
  - `rsp_valid[i]` = `dp_out_valid` && `tag`==i.
  - `dp_out_ready` = `rsp_ready[tag]`.
  - `rsp_data` = `dp_out_data`.
- Tag/data coherence: `tag` updates on the same edge on which the DPB loads its output register. One tag register is therefore sufficient.
- Widths:
  - `beat_cnt` is 4 bits.
  - `rr_ptr`, `grant_idx` and `tag` are $clog2(`NUM_REQ`) bits.
  - `rr_ptr` arithmetic wraps mod `NUM_REQ`.

## Timing
- Reset, at the first edge with `rst_n`=0:
  - state=IDLE, `rr_ptr`=0, `grant_idx`=0, `beat_cnt`=0, `tag`=0.
  - `req_ready`=0, `dp_valid`=0, `rsp_valid`=0.
  - `dp_data`=0 and `dp_mode`=0, because the datapath outputs are gated by state.
  - `dp_out_ready` follows `rsp_ready[0]`.
- Arbitration bubble: a request first visible in IDLE at cycle N is granted at edge N+1. `dp_valid` asserts in cycle N+1.
- Back-to-back beats within a grant: one beat per cycle while `dp_ready`=1.
- Release to IDLE costs one idle cycle before the next grant. A single requester streaming continuously therefore achieves `MAX_BURST`/(`MAX_BURST`+1) throughput.
- End-to-end latency from accept at edge N: the result appears on `rsp_valid`/`rsp_data` in cycle N+1 (DPB register stage). The arbiter adds no extra stage.
- Response backpressure:
  - `rsp_ready[tag]`=0 holds the DPB output.
  - `dp_ready` then drops and the granted requester stalls.
  - `beat_cnt` does not advance.
- Simultaneous events:
  - A release accept and a new `req_valid` on the same cycle: the new request is considered in IDLE on the next cycle.
  - Results for the previous tag and a new accept on the same edge: handled by the coherence rule above.
- Reset mid-burst: the grant is dropped and any in-flight DPB item is discarded. The DPB must be reset by the same (inverted) reset.

## Structure
- Shared package `dpb_pkg` holds:
  - the mode constants BYPASS=00, INC=01, INV=10, GAIN=11;
  - the arbiter state enum {ARB_IDLE, ARB_GRANT};
  - default `NUM_REQ`, `DATA_W` and `MAX_BURST`.
- Sub-module `dpb_rr_pick`: a combinational rotating-priority picker.
  - Inputs: req vector, `rr_ptr`.
  - Outputs: `any`, `idx`.
  - Reused by future schedulers.
- The top module instantiates `dpb_rr_pick`. The DPB itself is instantiated one level up.

## Test plan
- Single requester: req 1 sends 0x10, mode INC; `rsp_ready`=1.
  - `dp_valid` asserts 1 cycle after the request.
  - `rsp_valid[1]` with 0x11 one cycle after the accept.
  - All other `rsp_valid` bits stay 0.
- All 4 requesting continuously, `MAX_BURST`=4.
  - Grants rotate in order 0,1,2,3,0.
  - Exactly 4 beats per grant.
  - One idle cycle between grants.
  - Each result is tagged to its source (req 2 mode INV, 0x0F → 0xF0).
- Short burst: req 3 sends 2 beats then drops valid.
  - Release occurs in the drop cycle.
  - `rr_ptr`=0 afterwards.
  - Req 0 wins next even if req 1 is also requesting.
- Backpressure: hold `rsp_ready[0]`=0 for 3 cycles mid-burst.
  - `dp_ready`=0 and `req_ready[0]`=0 during the stall.
  - `beat_cnt` frozen.
  - No data lost or duplicated; GAIN mode 0x41 → 0x82.
- Reset mid-burst: `rst_n`=0 during a grant to req 2.
  - Next cycle: `req_ready`=0, `rsp_valid`=0, state IDLE, `rr_ptr`=0.
  - After release, req 2 is re-granted from IDLE.
- Wrap-around: `rr_ptr`=3 with req 0 and req 3 requesting.
  - Req 3 wins first; `rr_ptr` becomes 0; req 0 wins next.
